// File: rtl/cm_sketch_mc.sv
// rtl/cm_sketch_mc.sv - multi-channel count-min sketch with RAW forwarding and in-place clear sweep
// Build option HOT_FILTER_EN adds hot_thresh_i and suppresses out_valid_o for estimates below it.
module cm_sketch_mc #(
  parameter int NUM_CH    = 2,
  parameter int NUM_HASH  = 4,
  parameter int W         = 4096,
  parameter int ADDR_SIZE = 22,
  parameter int CNT_SIZE  = 18,
  parameter int COL_BITS  = $clog2(W),
  parameter int CH_BITS   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic [NUM_CH-1:0]           in_valid_i,
  input  logic [NUM_CH*ADDR_SIZE-1:0] in_addr_i,
  output logic [NUM_CH-1:0]           in_ready_o,
  input  logic                        clear_req_i,
`ifdef HOT_FILTER_EN
  input  logic [CNT_SIZE-1:0]         hot_thresh_i,
`endif
  output logic                        clear_busy_o,
  output logic                        out_valid_o,
  output logic [CH_BITS-1:0]          out_ch_o,
  output logic [ADDR_SIZE-1:0]        out_addr_o,
  output logic [CNT_SIZE-1:0]         out_cnt_o
);

  localparam logic [CNT_SIZE-1:0] CNT_MAX = {CNT_SIZE{1'b1}};
  localparam logic [15:0] HASH_K [4] = '{16'h9E37, 16'h85EB, 16'hC2B3, 16'h27D5};

  typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_SWEEP} state_e;

  state_e               state_q;
  logic [COL_BITS-1:0]  col_q;
  logic [1:0]           drain_q;
  logic                 clear_busy_q;
  logic [CH_BITS-1:0]   rr_q;

  logic                 accept_en;
  logic                 grant_any;
  logic [CH_BITS-1:0]   grant_idx;
  logic [NUM_CH-1:0]    grant;
  logic                 transfer;
  logic [ADDR_SIZE-1:0] sel_addr;
  logic [COL_BITS-1:0]  hash_col [NUM_HASH];

  logic                 p1_valid_q;
  logic [CH_BITS-1:0]   p1_ch_q;
  logic [ADDR_SIZE-1:0] p1_addr_q;
  logic [COL_BITS-1:0]  p1_col_q [NUM_HASH];

  logic                 p2_valid_q;
  logic [CH_BITS-1:0]   p2_ch_q;
  logic [ADDR_SIZE-1:0] p2_addr_q;
  logic [COL_BITS-1:0]  p2_col_q [NUM_HASH];

  logic                 p3_valid_q;
  logic [COL_BITS-1:0]  p3_col_q [NUM_HASH];
  logic [CNT_SIZE-1:0]  p3_cnt_q [NUM_HASH];

  logic [CNT_SIZE-1:0]  inc_cnt [NUM_HASH];
  logic [CNT_SIZE-1:0]  min_cnt;
  logic                 emit;

  logic                 out_valid_q;
  logic [CH_BITS-1:0]   out_ch_q;
  logic [ADDR_SIZE-1:0] out_addr_q;
  logic [CNT_SIZE-1:0]  out_cnt_q;

  // A clear request in the same cycle blocks all grants so the drain starts from a quiet input.
  assign accept_en = (state_q == ST_RUN) && !clear_req_i && !rst_i;

  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (!grant_any && in_valid_i[(int'(rr_q) + i) % NUM_CH]) begin
        grant_any = 1'b1;
        grant_idx = CH_BITS'((int'(rr_q) + i) % NUM_CH);
      end
    end
    grant    = '0;
    sel_addr = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (grant_idx == CH_BITS'(i)) begin
        grant[i] = accept_en && grant_any;
        sel_addr = in_addr_i[i*ADDR_SIZE +: ADDR_SIZE];
      end
    end
  end

  assign transfer   = accept_en && grant_any;
  assign in_ready_o = grant;

  // Multiply truncates to ADDR_SIZE bits; the column is the top COL_BITS of that product.
  always_comb begin
    for (int h = 0; h < NUM_HASH; h++) begin
      hash_col[h] = COL_BITS'((sel_addr * ADDR_SIZE'(HASH_K[h])) >> (ADDR_SIZE - COL_BITS));
    end
  end

  for (genvar h = 0; h < NUM_HASH; h++) begin : g_row
    logic [CNT_SIZE-1:0] mem [W];
    logic [CNT_SIZE-1:0] rd_q;
    logic [CNT_SIZE-1:0] cur_cnt;

    always_ff @(posedge clk_i) begin
      if (!rst_i) begin
        if (state_q == ST_SWEEP) begin
          mem[col_q] <= '0;
        end else if (p3_valid_q) begin
          mem[p3_col_q[h]] <= p3_cnt_q[h];
        end
      end
    end

    // The write landing on the same edge as this read would be missed by the RAM; take it directly.
    always_ff @(posedge clk_i) begin
      if (p3_valid_q && (p3_col_q[h] == p1_col_q[h])) begin
        rd_q <= p3_cnt_q[h];
      end else begin
        rd_q <= mem[p1_col_q[h]];
      end
    end

    assign cur_cnt    = (p3_valid_q && (p3_col_q[h] == p2_col_q[h])) ? p3_cnt_q[h] : rd_q;
    assign inc_cnt[h] = (cur_cnt == CNT_MAX) ? cur_cnt : cur_cnt + 1'b1;
  end

  always_comb begin
    min_cnt = inc_cnt[0];
    for (int h = 1; h < NUM_HASH; h++) begin
      if (inc_cnt[h] < min_cnt) begin
        min_cnt = inc_cnt[h];
      end
    end
  end

`ifdef HOT_FILTER_EN
  assign emit = p2_valid_q && (min_cnt >= hot_thresh_i);
`else
  assign emit = p2_valid_q;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= ST_SWEEP;
      col_q        <= '0;
      drain_q      <= '0;
      clear_busy_q <= 1'b1;
      rr_q         <= '0;
      p1_valid_q   <= 1'b0;
      p2_valid_q   <= 1'b0;
      p3_valid_q   <= 1'b0;
      out_valid_q  <= 1'b0;
      out_ch_q     <= '0;
      out_addr_q   <= '0;
      out_cnt_q    <= '0;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (clear_req_i) begin
            state_q      <= ST_DRAIN;
            drain_q      <= '0;
            clear_busy_q <= 1'b1;
          end
        end
        ST_DRAIN: begin
          if (drain_q == 2'd2) begin
            state_q <= ST_SWEEP;
            col_q   <= '0;
          end else begin
            drain_q <= drain_q + 2'd1;
          end
        end
        ST_SWEEP: begin
          if (col_q == COL_BITS'(W - 1)) begin
            state_q      <= ST_RUN;
            clear_busy_q <= 1'b0;
          end else begin
            col_q <= col_q + 1'b1;
          end
        end
        default: begin
          state_q      <= ST_SWEEP;
          col_q        <= '0;
          clear_busy_q <= 1'b1;
        end
      endcase

      if (transfer) begin
        rr_q <= (grant_idx == CH_BITS'(NUM_CH - 1)) ? '0 : grant_idx + 1'b1;
      end

      p1_valid_q  <= transfer;
      p2_valid_q  <= p1_valid_q;
      p3_valid_q  <= p2_valid_q;
      out_valid_q <= emit;
      if (p2_valid_q) begin
        out_ch_q   <= p2_ch_q;
        out_addr_q <= p2_addr_q;
        out_cnt_q  <= min_cnt;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (transfer) begin
      p1_ch_q   <= grant_idx;
      p1_addr_q <= sel_addr;
      p1_col_q  <= hash_col;
    end
    p2_ch_q   <= p1_ch_q;
    p2_addr_q <= p1_addr_q;
    p2_col_q  <= p1_col_q;
    p3_col_q  <= p2_col_q;
    p3_cnt_q  <= inc_cnt;
  end

  assign clear_busy_o = clear_busy_q;
  assign out_valid_o  = out_valid_q;
  assign out_ch_o     = out_ch_q;
  assign out_addr_o   = out_addr_q;
  assign out_cnt_o    = out_cnt_q;

endmodule

// File: tb/tb_cm_sketch_mc.sv
// tb/tb_cm_sketch_mc.sv - self-checking bench for cm_sketch_mc against a sequential sketch model
module tb_cm_sketch_mc;

  localparam int NCH  = 2;
  localparam int NH   = 4;
  localparam int WW   = 4096;
  localparam int AS   = 22;
  localparam int CS   = 4;
  localparam int CB   = 12;
  localparam int CHB  = 1;
  localparam int CMAX = (1 << CS) - 1;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NCH-1:0]    in_valid = '0;
  logic [NCH*AS-1:0] in_addr = '0;
  logic              clear_req = 1'b0;
  logic [NCH-1:0]    in_ready;
  logic              clear_busy;
  logic              out_valid;
  logic [CHB-1:0]    out_ch;
  logic [AS-1:0]     out_addr;
  logic [CS-1:0]     out_cnt;
`ifdef HOT_FILTER_EN
  logic [CS-1:0]     hot_thresh = '0;
`endif

  cm_sketch_mc #(
    .NUM_CH(NCH), .NUM_HASH(NH), .W(WW), .ADDR_SIZE(AS), .CNT_SIZE(CS)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .in_valid_i(in_valid),
    .in_addr_i(in_addr),
    .in_ready_o(in_ready),
    .clear_req_i(clear_req),
`ifdef HOT_FILTER_EN
    .hot_thresh_i(hot_thresh),
`endif
    .clear_busy_o(clear_busy),
    .out_valid_o(out_valid),
    .out_ch_o(out_ch),
    .out_addr_o(out_addr),
    .out_cnt_o(out_cnt)
  );

  always #5 clk = ~clk;

  typedef struct { int due; int ch; int addr; int cnt; } exp_t;
  typedef struct { int ch; int addr; int cnt; } obs_t;

  int n_checks = 0;
  int n_pass   = 0;

  int unsigned KM [4] = '{32'h9E37, 32'h85EB, 32'hC2B3, 32'h27D5};
  int unsigned sk [NH][WW];
  exp_t exq [$];
  obs_t obs [$];
  int   gl  [$];
  int   rr_m = 0;
  int   busy_left = WW;
  int   cyc = 0;
  bit   armed = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic int col_of(input int h, input int unsigned a);
    longint unsigned p;
    p = (longint'(a) * longint'(KM[h])) & ((64'd1 << AS) - 1);
    return int'(p >> (AS - CB));
  endfunction

  task automatic zero_sketch();
    for (int h = 0; h < NH; h++)
      for (int c = 0; c < WW; c++) sk[h][c] = 0;
  endtask

  // Model + compare: outputs are stable at the falling edge; the model then advances one cycle.
  always @(negedge clk) begin
    bit             eb;
    logic [NCH-1:0] er;
    int             g;
    int unsigned    a;
    int             mn;
    int             cc;
    int             thr;
    exp_t           e;
    obs_t           o;
    if (armed) begin
      if (rst) begin
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_cnt", out_cnt, 0);
        chk("rst_out_addr", out_addr, 0);
        chk("rst_out_ch", out_ch, 0);
        chk("rst_clear_busy", clear_busy, 1);
        chk("rst_in_ready", in_ready, 0);
        exq.delete();
        rr_m = 0;
        busy_left = WW;
        zero_sketch();
      end else begin
        eb = (busy_left > 0);
        er = '0;
        g  = -1;
        if (!eb && !clear_req) begin
          for (int i = 0; i < NCH; i++)
            if (g < 0 && in_valid[(rr_m + i) % NCH]) g = (rr_m + i) % NCH;
        end
        if (g >= 0) er[g] = 1'b1;
        chk("clear_busy", clear_busy, eb);
        chk("in_ready", in_ready, er);

        if (exq.size() > 0 && exq[0].due == cyc) begin
          e = exq.pop_front();
          chk("out_valid", out_valid, 1);
          chk("out_ch", out_ch, e.ch);
          chk("out_addr", out_addr, e.addr);
          chk("out_cnt", out_cnt, e.cnt);
        end else begin
          chk("out_valid_idle", out_valid, 0);
        end

        if (out_valid === 1'b1) begin
          o.ch = int'(out_ch); o.addr = int'(out_addr); o.cnt = int'(out_cnt);
          obs.push_back(o);
        end
        for (int i = 0; i < NCH; i++)
          if (in_ready[i] === 1'b1 && in_valid[i]) gl.push_back(i);

`ifdef HOT_FILTER_EN
        thr = int'(hot_thresh);
`else
        thr = 0;
`endif
        if (g >= 0) begin
          a  = int'(in_addr[g*AS +: AS]);
          mn = CMAX + 1;
          for (int h = 0; h < NH; h++) begin
            cc = col_of(h, a);
            if (sk[h][cc] < CMAX) sk[h][cc]++;
            if (int'(sk[h][cc]) < mn) mn = int'(sk[h][cc]);
          end
          if (mn >= thr) begin
            e.due = cyc + 3; e.ch = g; e.addr = int'(a); e.cnt = mn;
            exq.push_back(e);
          end
          rr_m = (g + 1) % NCH;
        end
        if (clear_req && !eb) begin
          busy_left = 3 + WW;
          zero_sketch();
        end else if (busy_left > 0) begin
          busy_left--;
        end
      end
      cyc++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [NCH-1:0] v, input int a0, input int a1);
    in_valid = v;
    in_addr[0*AS +: AS] = AS'(a0);
    in_addr[1*AS +: AS] = AS'(a1);
  endtask

  task automatic check_obs_cnts(input string name, input int n, input int cnts [$]);
    chk({name, "_len"}, obs.size(), n);
    for (int i = 0; i < n; i++)
      if (i < obs.size()) chk({name, "_cnt"}, obs[i].cnt, cnts[i]);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int q [$];
    logic [NCH-1:0] mv [5];
    int ma0 [5];
    int ma1 [5];

    drive(2'b11, 'h1, 'h2);
    @(posedge clk);
    #1 armed = 1'b1;
    repeat (2) step();
    rst = 1'b0;
    drive(2'b00, 0, 0);

    // Post-reset sweep length.
    n = 0;
    while (clear_busy && n < WW + 20) begin
      n++;
      step();
    end
    chk("init_busy_len", n, WW);

    // Two channels held valid: grants alternate starting from channel 0.
    obs.delete(); gl.delete();
    drive(2'b11, 'h10, 'h20);
    repeat (4) step();
    drive(2'b00, 0, 0);
    repeat (6) step();
    chk("rr_len", gl.size(), 4);
    for (int i = 0; i < 4; i++) if (i < gl.size()) chk("rr_grant", gl[i], i % 2);
    chk("alt_len", obs.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < obs.size()) begin
        chk("alt_ch", obs[i].ch, i % 2);
        chk("alt_addr", obs[i].addr, (i % 2) ? 'h20 : 'h10);
        chk("alt_cnt", obs[i].cnt, (i / 2) + 1);
      end
    end

    // Back-to-back same address exercises both forwarding paths.
    obs.delete();
    drive(2'b01, 'h123, 0);
    repeat (3) step();
    drive(2'b00, 0, 0);
    repeat (6) step();
    q = '{1, 2, 3};
    check_obs_cnts("fwd", 3, q);

    // Mixed valid patterns, including an all-ones address.
    mv  = '{2'b10, 2'b11, 2'b01, 2'b00, 2'b11};
    ma0 = '{'h1, 'h123, 'h10, 'h0, 'h0};
    ma1 = '{'h3FFFFF, 'h5, 'h0, 'h0, 'h0};
    for (int i = 0; i < 5; i++) begin
      drive(mv[i], ma0[i], ma1[i]);
      step();
    end
    drive(2'b00, 0, 0);
    repeat (6) step();

    // Clear after two updates of 'h5: in-flight results still come out, then counters are zero.
    clear_req = 1'b1;
    step();
    clear_req = 1'b0;
    n = 0;
    while (clear_busy && n < WW + 40) begin
      n++;
      step();
    end
    obs.delete();
    drive(2'b01, 'h5, 0);
    repeat (2) step();
    clear_req = 1'b1;
    step();
    clear_req = 1'b0;
    drive(2'b00, 0, 0);
    n = 0;
    while (clear_busy && n < WW + 40) begin
      n++;
      clear_req = (n == 10);
      step();
    end
    clear_req = 1'b0;
    chk("clear_busy_len", n, 3 + WW);
    q = '{1, 2};
    check_obs_cnts("clr_drain", 2, q);
    obs.delete();
    drive(2'b01, 'h5, 0);
    step();
    drive(2'b00, 0, 0);
    repeat (6) step();
    q = '{1};
    check_obs_cnts("clr_after", 1, q);

    // Saturation with 4-bit counters.
    obs.delete();
    drive(2'b01, 'h0, 0);
    repeat (17) step();
    drive(2'b00, 0, 0);
    repeat (6) step();
    q = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15, 15, 15};
    check_obs_cnts("sat", 17, q);

`ifdef HOT_FILTER_EN
    obs.delete();
    hot_thresh = 4'd3;
    drive(2'b01, 'h7, 0);
    repeat (4) step();
    drive(2'b00, 0, 0);
    repeat (6) step();
    q = '{3, 4};
    check_obs_cnts("hot", 2, q);
    hot_thresh = '0;
`endif

    repeat (4) step();
    chk("pending_drained", exq.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
